// File: rtl/vga_pixel_serializer_if.sv
// Load-side handshake between fetch logic and the pixel serializer.
// PIXEL_INVERT_EN adds a per-word invert flag that travels with word_in.
interface vga_pixel_serializer_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] word_in;
  logic             word_valid;
  logic             word_ready;
`ifdef PIXEL_INVERT_EN
  logic             word_invert;

  modport master (output word_in, word_valid, word_invert, input word_ready);
  modport slave  (input word_in, word_valid, word_invert, output word_ready);
`else
  modport master (output word_in, word_valid, input word_ready);
  modport slave  (input word_in, word_valid, output word_ready);
`endif
endinterface

// File: rtl/vga_pixel_serializer.sv
// Word-to-pixel shifter with one-word holding buffer, bit order select, pixel repeat and underrun flags.
// Optional PIXEL_INVERT_EN: per-word invert flag XORed onto shifted pixels.
module vga_pixel_serializer #(
  parameter int WIDTH     = 8,
  parameter int SCALE     = 1,
  parameter int LSB_FIRST = 0
) (
  input  logic vga_clk,
  input  logic reset,
  input  logic display_area,
  vga_pixel_serializer_if.slave load,
  output logic pixel_out,
  output logic pixel_active,
  output logic underrun,
  output logic underrun_seen
);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(SCALE - 1);
  localparam int FIRST = (LSB_FIRST != 0) ? 0 : WIDTH - 1;

  logic [WIDTH-1:0] hold, shreg;
  logic             hold_full;
  logic [BW-1:0]    bit_idx, pos;
  logic [RW-1:0]    rep_cnt;
  logic             hold_inv, sh_inv;
  logic             word_start, xfer, consume;

  assign load.word_ready = ~hold_full;
  assign xfer       = load.word_valid & ~hold_full;
  assign word_start = (bit_idx == '0) && (rep_cnt == '0);
  assign consume    = display_area & word_start & hold_full;
  assign pos        = (LSB_FIRST != 0) ? bit_idx : BIT_LAST - bit_idx;

`ifdef PIXEL_INVERT_EN
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hold_inv <= 1'b0;
      sh_inv   <= 1'b0;
    end else begin
      if (xfer) hold_inv <= load.word_invert;
      // underrun slots shift zeros and must stay zero, so drop the invert too
      if (display_area && word_start) sh_inv <= hold_full ? hold_inv : 1'b0;
    end
  end
`else
  assign hold_inv = 1'b0;
  assign sh_inv   = 1'b0;
`endif

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hold          <= '0;
      hold_full     <= 1'b0;
      shreg         <= '0;
      bit_idx       <= '0;
      rep_cnt       <= '0;
      pixel_out     <= 1'b0;
      pixel_active  <= 1'b0;
      underrun      <= 1'b0;
      underrun_seen <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (xfer) hold <= load.word_in;
      // ready is low whenever a consume can happen, so load and consume never collide
      if (consume)   hold_full <= 1'b0;
      else if (xfer) hold_full <= 1'b1;

      if (!display_area) begin
        // blanking discards any partial word but keeps the prefetched hold
        bit_idx      <= '0;
        rep_cnt      <= '0;
        pixel_out    <= 1'b0;
        pixel_active <= 1'b0;
      end else begin
        if (word_start) begin
          if (hold_full) begin
            shreg        <= hold;
            pixel_out    <= hold[FIRST] ^ hold_inv;
            pixel_active <= 1'b1;
          end else begin
            underrun      <= 1'b1;
            underrun_seen <= 1'b1;
            shreg         <= '0;
            pixel_out     <= 1'b0;
            pixel_active  <= 1'b0;
          end
        end else begin
          pixel_out <= shreg[pos] ^ sh_inv;
        end

        if (rep_cnt == REP_LAST) begin
          rep_cnt <= '0;
          bit_idx <= (bit_idx == BIT_LAST) ? '0 : bit_idx + BW'(1);
        end else begin
          rep_cnt <= rep_cnt + RW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_vga_pixel_serializer.sv
// Bench: dut0 = 8-bit MSB-first x1, dut1 = 8-bit LSB-first x2; expected pixels queued per DUT.
module tb_vga_pixel_serializer;
  logic vga_clk = 1'b0;
  logic reset;
  logic da0, da1;
  logic pix0, act0, ur0, us0;
  logic pix1, act1, ur1, us1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 vga_clk = ~vga_clk;

  vga_pixel_serializer_if #(.WIDTH(8)) if0 ();
  vga_pixel_serializer_if #(.WIDTH(8)) if1 ();

  vga_pixel_serializer #(.WIDTH(8), .SCALE(1), .LSB_FIRST(0)) dut0 (
    .vga_clk(vga_clk), .reset(reset), .display_area(da0), .load(if0),
    .pixel_out(pix0), .pixel_active(act0), .underrun(ur0), .underrun_seen(us0));

  vga_pixel_serializer #(.WIDTH(8), .SCALE(2), .LSB_FIRST(1)) dut1 (
    .vga_clk(vga_clk), .reset(reset), .display_area(da1), .load(if1),
    .pixel_out(pix1), .pixel_active(act1), .underrun(ur1), .underrun_seen(us1));

  typedef struct packed { logic pix; logic act; logic ur; } exp_t;
  typedef struct { logic [7:0] word; logic [7:0] exp0; logic [15:0] exp1; } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  vec_t vecs[5];

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic [7:0] w);
    if (sel) begin if1.word_valid = v; if1.word_in = w; end
    else     begin if0.word_valid = v; if0.word_in = w; end
  endtask

  task automatic push(input bit sel, input logic p, input logic a, input logic u);
    exp_t e;
    e = '{pix: p, act: a, ur: u};
    if (sel) q1.push_back(e);
    else     q0.push_back(e);
  endtask

  task automatic step_chk(input bit sel);
    exp_t e;
    int   n;
    step();
    n = sel ? q1.size() : q0.size();
    if (n == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_empty: got no expected entry for dut%0d at %0t", sel, $time);
    end else if (sel) begin
      e = q1.pop_front();
      chk("pix1", pix1, e.pix); chk("act1", act1, e.act); chk("ur1", ur1, e.ur);
    end else begin
      e = q0.pop_front();
      chk("pix0", pix0, e.pix); chk("act0", act0, e.act); chk("ur0", ur0, e.ur);
    end
  endtask

  // Streams all table words back to back; the next word is offered one cycle into each slot.
  task automatic stream(input bit sel);
    int slot;
    slot = sel ? 16 : 8;
    for (int i = 0; i < 5; i++)
      for (int k = 0; k < slot; k++)
        push(sel, sel ? vecs[i].exp1[15-k] : vecs[i].exp0[7-k], 1'b1, 1'b0);
    drive(sel, 1'b1, vecs[0].word);
    step();
    drive(sel, 1'b0, 8'h00);
    chk(sel ? "ready1_loaded" : "ready0_loaded", sel ? if1.word_ready : if0.word_ready, 1'b0);
    if (sel) da1 = 1'b1; else da0 = 1'b1;
    for (int c = 0; c < 5 * slot; c++) begin
      if ((c % slot) == 1 && (c / slot) < 4) drive(sel, 1'b1, vecs[c / slot + 1].word);
      step_chk(sel);
      drive(sel, 1'b0, 8'h00);
      if (c == 0) chk(sel ? "ready1_consumed" : "ready0_consumed",
                      sel ? if1.word_ready : if0.word_ready, 1'b1);
    end
    if (sel) da1 = 1'b0; else da0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{8'hA5, 8'hA5, 16'hCC33};
    vecs[1] = '{8'h01, 8'h01, 16'hC000};
    vecs[2] = '{8'h80, 8'h80, 16'h0003};
    vecs[3] = '{8'hC0, 8'hC0, 16'h000F};
    vecs[4] = '{8'h12, 8'h12, 16'h30C0};

    reset = 1'b1; da0 = 1'b0; da1 = 1'b0;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
`ifdef PIXEL_INVERT_EN
    if0.word_invert = 1'b0;
    if1.word_invert = 1'b0;
`endif
    step(); step();
    chk("rst_pix0", pix0, 0); chk("rst_act0", act0, 0); chk("rst_ur0", ur0, 0);
    chk("rst_us0", us0, 0);   chk("rst_ready0", if0.word_ready, 1);
    chk("rst_pix1", pix1, 0); chk("rst_ready1", if1.word_ready, 1);
    #2 reset = 1'b0;

    stream(1);
    chk("us1_clean", us1, 0);
    stream(0);
    chk("us0_clean", us0, 0);

    // Underrun slot, FF arrives during it
    da0 = 1'b1;
    push(0, 0, 0, 1);
    for (int k = 0; k < 7; k++) push(0, 0, 0, 0);
    for (int c = 0; c < 8; c++) begin
      if (c == 1) drive(0, 1'b1, 8'hFF);
      step_chk(0);
      drive(0, 1'b0, 8'h00);
    end
    chk("us0_sticky", us0, 1);

    // Blank after three bits of FF with 0F held, then resume from hold
    for (int k = 0; k < 3; k++) push(0, 1, 1, 0);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) drive(0, 1'b1, 8'h0F);
      step_chk(0);
      drive(0, 1'b0, 8'h00);
    end
    da0 = 1'b0;
    push(0, 0, 0, 0); push(0, 0, 0, 0);
    step_chk(0); step_chk(0);
    chk("ready0_hold_kept", if0.word_ready, 0);
    da0 = 1'b1;
    for (int k = 0; k < 8; k++) push(0, (k >= 4), 1, 0);
    for (int c = 0; c < 8; c++) step_chk(0);
    da0 = 1'b0;
    push(0, 0, 0, 0);
    step_chk(0);
    chk("us0_still_set", us0, 1);

`ifdef PIXEL_INVERT_EN
    if0.word_invert = 1'b1;
    drive(0, 1'b1, 8'hF0);
    step();
    drive(0, 1'b0, 8'h00);
    if0.word_invert = 1'b0;
    for (int k = 0; k < 8; k++) push(0, (k >= 4), 1, 0);
    da0 = 1'b1;
    for (int c = 0; c < 8; c++) step_chk(0);
    da0 = 1'b0;
    push(0, 0, 0, 0);
    step_chk(0);
`endif

    // Asynchronous reset in the middle of a word
    drive(0, 1'b1, 8'hFF);
    step();
    drive(0, 1'b0, 8'h00);
    da0 = 1'b1;
    for (int k = 0; k < 3; k++) push(0, 1, 1, 0);
    for (int c = 0; c < 3; c++) step_chk(0);
    #2 reset = 1'b1;
    #1;
    chk("midrst_pix0", pix0, 0); chk("midrst_act0", act0, 0);
    chk("midrst_us0", us0, 0);   chk("midrst_ready0", if0.word_ready, 1);
    da0 = 1'b0;
    step();
    #2 reset = 1'b0;
    step();
    chk("post_rst_pix0", pix0, 0);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
